mem_port_arbiter: RTL and testbench

Sequencing arbiter that shares the single memory port of the system between three requesters: instruction fetch, data load and data store. It accepts at most one transaction at a time, issues it to the memory over a valid/ready request channel, and routes the response back to the owning requester. The block has a response timeout that returns an error, and a starvation guard that keeps fetch from being locked out by data traffic. It sits between the processor core's fetch/memRead/memWrite ports and the memory32 instance.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch, load and store requesters.
// Accepts one transaction at a time, issues it, and routes the response or a timeout error back.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_req_addr,
  input  logic              read_req_valid,
  output logic              read_req_ready,
  input  logic [ADDR_W-1:0] read_req_addr,
  input  logic              write_req_valid,
  output logic              write_req_ready,
  input  logic [ADDR_W-1:0] write_req_addr,
  input  logic [DATA_W-1:0] write_req_data,
  output logic              fetch_resp_valid,
  output logic [DATA_W-1:0] fetch_resp_data,
  output logic              fetch_resp_err,
  output logic              read_resp_valid,
  output logic [DATA_W-1:0] read_resp_data,
  output logic              read_resp_err,
  output logic              write_resp_valid,
  output logic              write_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              mem_resp_err
);

  localparam int SC_W = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_F = 2'd0, OWN_R = 2'd1, OWN_W = 2'd2} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              write_q, write_d;
  logic [7:0]        timer_q, timer_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [2:0]        resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              fetch_promoted;

  assign fetch_promoted = fetch_req_valid && (starve_cnt_q >= SC_W'(STARVE_LIMIT));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      owner_q      <= OWN_F;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      timer_q      <= '0;
      starve_cnt_q <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      write_q      <= write_d;
      timer_q      <= timer_d;
      starve_cnt_q <= starve_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    data_d       = data_q;
    write_d      = write_q;
    timer_d      = timer_q;
    resp_valid_d = '0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;

    if (fetch_req_valid && !fetch_req_ready)
      starve_cnt_d = (starve_cnt_q == '1) ? starve_cnt_q : starve_cnt_q + SC_W'(1);
    else
      starve_cnt_d = '0;

    case (state_q)
      IDLE: begin
        if (write_req_ready) begin
          owner_d = OWN_W;
          addr_d  = write_req_addr;
          data_d  = write_req_data;
          write_d = 1'b1;
          state_d = ISSUE;
        end else if (read_req_ready) begin
          owner_d = OWN_R;
          addr_d  = read_req_addr;
          data_d  = '0;
          write_d = 1'b0;
          state_d = ISSUE;
        end else if (fetch_req_ready) begin
          owner_d = OWN_F;
          addr_d  = fetch_req_addr;
          data_d  = '0;
          write_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        // A real response takes precedence over a coincident timeout.
        if (mem_resp_valid) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_data_d           = mem_resp_data;
          resp_err_d            = mem_resp_err;
          state_d               = IDLE;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_err_d            = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is combinational in IDLE; a promoted fetch overrides the fixed W > R > F order.
  always_comb begin
    fetch_req_ready = 1'b0;
    read_req_ready  = 1'b0;
    write_req_ready = 1'b0;
    if (state_q == IDLE && !RESET) begin
      if (fetch_promoted)       fetch_req_ready = 1'b1;
      else if (write_req_valid) write_req_ready = 1'b1;
      else if (read_req_valid)  read_req_ready  = 1'b1;
      else if (fetch_req_valid) fetch_req_ready = 1'b1;
    end
    mem_req_valid = (state_q == ISSUE);
  end

  assign mem_req_write    = write_q;
  assign mem_req_addr     = addr_q;
  assign mem_req_data     = data_q;

  assign fetch_resp_valid = resp_valid_q[OWN_F];
  assign read_resp_valid  = resp_valid_q[OWN_R];
  assign write_resp_valid = resp_valid_q[OWN_W];
  assign fetch_resp_data  = resp_valid_q[OWN_F] ? resp_data_q : '0;
  assign read_resp_data   = resp_valid_q[OWN_R] ? resp_data_q : '0;
  assign fetch_resp_err   = resp_valid_q[OWN_F] & resp_err_q;
  assign read_resp_err    = resp_valid_q[OWN_R] & resp_err_q;
  assign write_resp_err   = resp_valid_q[OWN_W] & resp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, starvation, timeout, backpressure, reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        fetch_req_valid, read_req_valid, write_req_valid;
  logic        fetch_req_ready, read_req_ready, write_req_ready;
  logic [31:0] fetch_req_addr, read_req_addr, write_req_addr, write_req_data;
  logic        fetch_resp_valid, read_resp_valid, write_resp_valid;
  logic [31:0] fetch_resp_data, read_resp_data;
  logic        fetch_resp_err, read_resp_err, write_resp_err;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_data;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8), .TIMEOUT(16)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready), .fetch_req_addr(fetch_req_addr),
    .read_req_valid(read_req_valid), .read_req_ready(read_req_ready), .read_req_addr(read_req_addr),
    .write_req_valid(write_req_valid), .write_req_ready(write_req_ready), .write_req_addr(write_req_addr),
    .write_req_data(write_req_data),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data), .fetch_resp_err(fetch_resp_err),
    .read_resp_valid(read_resp_valid), .read_resp_data(read_resp_data), .read_resp_err(read_resp_err),
    .write_resp_valid(write_resp_valid), .write_resp_err(write_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(negedge CLK);
  endtask

  function automatic logic [31:0] readies();
    return {29'd0, fetch_req_ready, read_req_ready, write_req_ready};
  endfunction

  function automatic logic [31:0] resps();
    return {29'd0, fetch_resp_valid, read_resp_valid, write_resp_valid};
  endfunction

  // Called in the handshake cycle; returns in the response cycle. drop = {f,r,w} valids to release.
  task automatic serve(input logic [31:0] exp_addr, input logic exp_write, input logic [31:0] exp_data,
                       input logic [31:0] rdata, input logic rerr, input logic [2:0] drop);
    next_cycle();
    if (drop[2]) fetch_req_valid = 1'b0;
    if (drop[1]) read_req_valid  = 1'b0;
    if (drop[0]) write_req_valid = 1'b0;
    #1;
    check_output("issue_valid", mem_req_valid, 1);
    check_output("issue_addr", mem_req_addr, exp_addr);
    check_output("issue_write", mem_req_write, exp_write);
    if (exp_write) check_output("issue_data", mem_req_data, exp_data);
    next_cycle();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    mem_resp_err   = rerr;
    #1;
    check_output("wait_no_resp", resps(), 0);
    next_cycle();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    {fetch_req_valid, write_req_valid, mem_req_ready, mem_resp_valid, mem_resp_err} = '0;
    {fetch_req_addr, read_req_addr, write_req_addr, write_req_data, mem_resp_data} = '0;
    read_req_valid = 1'b1;
    #3;
    check_output("rst_ready", readies(), 0);
    check_output("rst_mem_valid", mem_req_valid, 0);
    check_output("rst_mem_write", mem_req_write, 0);
    check_output("rst_mem_addr", mem_req_addr, 0);
    check_output("rst_resp", resps(), 0);
    next_cycle();
    RESET = 1'b0;
    read_req_valid = 1'b0;
    mem_req_ready = 1'b1;

    // Single load
    next_cycle();
    read_req_valid = 1'b1;
    read_req_addr = 32'h100;
    #1;
    check_output("load_ready", readies(), 3'b010);
    check_output("load_mem_idle", mem_req_valid, 0);
    serve(32'h100, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3'b010);
    check_output("load_resp", resps(), 3'b010);
    check_output("load_data", read_resp_data, 32'hDEADBEEF);
    check_output("load_err", read_resp_err, 0);
    next_cycle();
    #1;
    check_output("load_resp_end", resps(), 0);
    check_output("load_data_zero", read_resp_data, 0);

    // Priority W > R > F
    next_cycle();
    write_req_valid = 1'b1; write_req_addr = 32'h200; write_req_data = 32'hCAFEF00D;
    read_req_valid  = 1'b1; read_req_addr  = 32'h204;
    fetch_req_valid = 1'b1; fetch_req_addr = 32'h208;
    #1;
    check_output("prio_grant_w", readies(), 3'b001);
    serve(32'h200, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0, 3'b001);
    check_output("prio_resp_w", resps(), 3'b001);
    check_output("prio_grant_r", readies(), 3'b010);
    serve(32'h204, 1'b0, 32'h0, 32'h11111111, 1'b0, 3'b010);
    check_output("prio_resp_r", resps(), 3'b010);
    check_output("prio_data_r", read_resp_data, 32'h11111111);
    check_output("prio_grant_f", readies(), 3'b100);
    serve(32'h208, 1'b0, 32'h0, 32'h22222222, 1'b0, 3'b100);
    check_output("prio_resp_f", resps(), 3'b100);
    check_output("prio_data_f", fetch_resp_data, 32'h22222222);
    check_output("prio_none", readies(), 0);

    // Starvation: R held valid, F waits until promoted
    next_cycle();
    read_req_valid = 1'b1;  read_req_addr = 32'h300;
    fetch_req_valid = 1'b1; fetch_req_addr = 32'h400;
    #1;
    check_output("starve_grant_r0", readies(), 3'b010);
    serve(32'h300, 1'b0, 32'h0, 32'h33, 1'b0, 3'b000);
    check_output("starve_grant_r1", readies(), 3'b010);
    serve(32'h300, 1'b0, 32'h0, 32'h33, 1'b0, 3'b000);
    check_output("starve_grant_r2", readies(), 3'b010);
    serve(32'h300, 1'b0, 32'h0, 32'h33, 1'b0, 3'b000);
    check_output("starve_grant_f", readies(), 3'b100);
    next_cycle();
    fetch_req_valid = 1'b0;
    #1;
    check_output("starve_cnt_clear", 32'(dut.starve_cnt_q), 0);
    check_output("starve_issue_addr", mem_req_addr, 32'h400);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h44;
    #1;
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    #1;
    check_output("starve_resp_f", resps(), 3'b100);
    check_output("starve_data_f", fetch_resp_data, 32'h44);
    check_output("starve_regrant_r", readies(), 3'b010);
    serve(32'h300, 1'b0, 32'h0, 32'h55, 1'b0, 3'b010);
    check_output("starve_resp_r", resps(), 3'b010);

    // Timeout: memory accepts but never answers
    next_cycle();
    read_req_valid = 1'b1; read_req_addr = 32'h500;
    #1;
    check_output("to_grant", readies(), 3'b010);
    next_cycle();
    read_req_valid = 1'b0;
    #1;
    check_output("to_issue", mem_req_valid, 1);
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      #1;
      check_output("to_early", resps(), 0);
    end
    next_cycle();
    #1;
    check_output("to_resp", resps(), 3'b010);
    check_output("to_err", read_resp_err, 1);
    check_output("to_data", read_resp_data, 0);
    next_cycle();
    #1;
    check_output("to_resp_end", resps(), 0);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h66;
    #1;
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    #1;
    check_output("to_late_ignored", resps(), 0);
    next_cycle();
    #1;
    check_output("to_late_ignored2", resps(), 0);

    // Backpressure with a stale response during ISSUE, then an error response
    next_cycle();
    mem_req_ready = 1'b0;
    write_req_valid = 1'b1; write_req_addr = 32'h600; write_req_data = 32'h77777777;
    read_req_valid  = 1'b1; read_req_addr  = 32'h604;
    fetch_req_valid = 1'b1; fetch_req_addr = 32'h608;
    #1;
    check_output("bp_grant_w", readies(), 3'b001);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      write_req_valid = 1'b0;
      mem_resp_valid = (i == 2);
      #1;
      check_output("bp_valid", mem_req_valid, 1);
      check_output("bp_addr", mem_req_addr, 32'h600);
      check_output("bp_data", mem_req_data, 32'h77777777);
      check_output("bp_write", mem_req_write, 1);
      check_output("bp_no_ready", readies(), 0);
      check_output("bp_no_resp", resps(), 0);
    end
    next_cycle();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    read_req_valid = 1'b0; fetch_req_valid = 1'b0;
    #1;
    check_output("bp_release", mem_req_valid, 1);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_err = 1'b1;
    #1;
    check_output("bp_wait", resps(), 0);
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    #1;
    check_output("bp_resp_w", resps(), 3'b001);
    check_output("bp_err_w", write_resp_err, 1);

    // Reset asserted in WAIT
    next_cycle();
    read_req_valid = 1'b1; read_req_addr = 32'h700;
    #1;
    check_output("rw_grant", readies(), 3'b010);
    next_cycle();
    read_req_valid = 1'b0;
    #1;
    check_output("rw_issue", mem_req_valid, 1);
    next_cycle();
    #1;
    RESET = 1'b1;
    #1;
    check_output("rw_mem_valid", mem_req_valid, 0);
    check_output("rw_mem_addr", mem_req_addr, 0);
    check_output("rw_ready", readies(), 0);
    check_output("rw_resp", resps(), 0);
    next_cycle();
    RESET = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
    #1;
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    #1;
    check_output("rw_no_pulse", resps(), 0);
    check_output("rw_idle", mem_req_valid, 0);
    next_cycle();
    read_req_valid = 1'b1; read_req_addr = 32'h704;
    #1;
    check_output("rw_new_grant", readies(), 3'b010);
    serve(32'h704, 1'b0, 32'h0, 32'h88, 1'b0, 3'b010);
    check_output("rw_new_resp", resps(), 3'b010);
    check_output("rw_new_data", read_resp_data, 32'h88);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
